// File: rtl/cnt_pkg.sv
// Shared definitions for the down-counter timer family: FSM state encoding
// and default counter width.
package cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned CNT_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/bin_dncnt_core.sv
// Plain loadable binary down counter with synchronous active-high reset.
// Priority: Reset > Load > CE.
module bin_dncnt_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             CE,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clk) begin
        if (Reset) begin
            Q <= '0;
        end else if (Load) begin
            Q <= D;
        end else if (CE) begin
            Q <= Q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/bin_dncnt4_timer.sv
// Down-counting timer: Start kicks a countdown of the loaded value, Done pulses
// for one cycle at zero, optionally reloading and running again.
module bin_dncnt4_timer
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH       = CNT_WIDTH_DEFAULT,
    parameter int unsigned AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             CE,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic             TC
);

    state_e           state, state_next;
    logic [WIDTH-1:0] reload;
    logic             core_ce;
    logic             core_load;
    logic [WIDTH-1:0] core_d;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state  <= IDLE;
            reload <= '0;
        end else begin
            state <= state_next;
            if (Load) begin
                reload <= D;
            end
        end
    end

    // The counter core is steered by the FSM: it decrements only in RUN and
    // is re-loaded from the reload register when an auto-reload cycle starts.
    always_comb begin
        state_next = state;
        core_ce    = 1'b0;
        core_load  = Load;
        core_d     = D;
        if (Load) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        state_next = (Q != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (CE) begin
                        core_ce = 1'b1;
                        if (Q == WIDTH'(1)) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (AUTO_RELOAD != 0 && reload != '0) begin
                        core_load  = 1'b1;
                        core_d     = reload;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    bin_dncnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .Reset (Reset),
        .CE    (core_ce),
        .Load  (core_load),
        .D     (core_d),
        .Q     (Q)
    );

    assign Busy = (state == RUN);
    assign Done = (state == DONE);
    assign TC   = CE & (Q == '0);

endmodule

// File: tb/tb_bin_dncnt4_timer.sv
// Bench for bin_dncnt4_timer: one instance without and one with auto-reload,
// driven identically and compared every cycle against a behavioural model.
module tb_bin_dncnt4_timer;

    logic       clk = 1'b0;
    logic       Reset, CE, Load, Start;
    logic [3:0] D;
    logic [3:0] q0, q1;
    logic       busy0, busy1, done0, done1, tc0, tc1;

    int errors = 0;
    int checks = 0;

    // Reference state per instance: count, last loaded value, phase
    // (0 = waiting, 1 = counting, 2 = finished this cycle).
    int m_q[2];
    int m_rel[2];
    int m_phase[2];

    always #5 clk = ~clk;

    bin_dncnt4_timer #(.WIDTH(4), .AUTO_RELOAD(0)) u_dut0 (
        .clk(clk), .Reset(Reset), .CE(CE), .Load(Load), .D(D), .Start(Start),
        .Q(q0), .Busy(busy0), .Done(done0), .TC(tc0)
    );

    bin_dncnt4_timer #(.WIDTH(4), .AUTO_RELOAD(1)) u_dut1 (
        .clk(clk), .Reset(Reset), .CE(CE), .Load(Load), .D(D), .Start(Start),
        .Q(q1), .Busy(busy1), .Done(done1), .TC(tc1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit ar, input bit r, input bit ce,
                              input bit ld, input int d, input bit st);
        if (r) begin
            m_q[i] = 0; m_rel[i] = 0; m_phase[i] = 0;
        end else if (ld) begin
            m_q[i] = d; m_rel[i] = d; m_phase[i] = 0;
        end else if (m_phase[i] == 0) begin
            if (st) m_phase[i] = (m_q[i] == 0) ? 2 : 1;
        end else if (m_phase[i] == 1) begin
            if (ce) begin
                m_q[i] = m_q[i] - 1;
                if (m_q[i] == 0) m_phase[i] = 2;
            end
        end else begin
            if (ar && m_rel[i] != 0) begin
                m_q[i] = m_rel[i]; m_phase[i] = 1;
            end else begin
                m_phase[i] = 0;
            end
        end
    endtask

    task automatic compare_all(input bit ce);
        check("q0",    int'(q0),    m_q[0]);
        check("busy0", int'(busy0), int'(m_phase[0] == 1));
        check("done0", int'(done0), int'(m_phase[0] == 2));
        check("tc0",   int'(tc0),   int'(ce && m_q[0] == 0));
        check("q1",    int'(q1),    m_q[1]);
        check("busy1", int'(busy1), int'(m_phase[1] == 1));
        check("done1", int'(done1), int'(m_phase[1] == 2));
        check("tc1",   int'(tc1),   int'(ce && m_q[1] == 0));
    endtask

    // Apply inputs for one edge (called just after a falling edge), then check.
    task automatic tick(input bit r, input bit ce, input bit ld, input int d, input bit st);
        Reset = r; CE = ce; Load = ld; D = 4'(d); Start = st;
        @(posedge clk);
        model_step(0, 1'b0, r, ce, ld, d, st);
        model_step(1, 1'b1, r, ce, ld, d, st);
        @(negedge clk);
        compare_all(ce);
    endtask

    initial begin
        int n;
        bit seen;
        Reset = 1'b1; CE = 1'b0; Load = 1'b0; D = 4'd0; Start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0; m_rel[i] = 0; m_phase[i] = 0;
        end
        @(negedge clk);

        // Reset dominates a simultaneous load
        tick(1, 0, 1, 9, 0);
        tick(1, 1, 1, 9, 0);
        tick(0, 1, 0, 0, 0);

        // Basic countdown with latency measured from the Start edge
        tick(0, 1, 1, 5, 0);
        tick(0, 1, 0, 0, 1);
        n = 1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick(0, 1, 0, 0, 0);
            n++;
            seen = done0;
        end
        check("latency5", seen ? n : -1, 6);
        tick(0, 1, 1, 0, 0);
        tick(0, 1, 0, 0, 0);

        // CE gating
        tick(0, 0, 1, 3, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);

        // Abort by load with a same-edge Start
        tick(0, 1, 1, 6, 0);
        tick(0, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 1, 2, 1);
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);

        // Start from zero, and Start ignored while running
        tick(0, 1, 1, 0, 0);
        tick(0, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 1, 4, 0);
        tick(0, 1, 0, 0, 1);
        for (int k = 0; k < 6; k++) tick(0, 1, 0, 0, 1);
        tick(0, 1, 1, 0, 0);

        // Auto-reload period, then reset mid-run
        tick(0, 1, 1, 2, 0);
        tick(0, 1, 0, 0, 1);
        for (int k = 0; k < 8; k++) tick(0, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
